// File: rtl/can_host_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// can_host_seq
//
// Autonomous bus master for one CAN controller's register slave port. After
// reset it runs the init sequence (enter reset mode, program BTR0/BTR1, leave
// reset mode), then idles in READY. Each start pulse loads ID1/ID2 and up to
// eight data bytes, writes the TX request, and polls status bit 3 until the
// frame completes or POLL_LIMIT cycles pass.
//
// Optional build macro: CAN_HOST_SEQ_IRQ_EN
//   defined   : each status read waits for irq_i instead of a 4-cycle gap
//   undefined : irq_i is ignored, fixed 4-cycle gap between status reads
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start_i         : one-cycle frame request, honoured only in READY
//   id_i/rtr_i/dlc_i/data_i : frame contents, latched on start_i
//   irq_i           : controller interrupt (IRQ build only)
//   req_o/we_o/addr_o/be_o/wdata_o : registered bus request fields
//   gnt_i/rvalid_i/rdata_i         : slave grant and response
//   ready_o/busy_o  : idle after init / init or transfer in progress
//   done_o          : one-cycle pulse at the end of a transfer
//   tx_ok_o/timeout_o : result of the last transfer
// ---------------------------------------------------------------------------
module can_host_seq #(
  parameter logic [7:0]  BTR0_VAL   = 8'h00,
  parameter logic [7:0]  BTR1_VAL   = 8'h00,
  parameter int unsigned POLL_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [10:0] id_i,
  input  logic        rtr_i,
  input  logic [3:0]  dlc_i,
  input  logic [63:0] data_i,
  input  logic        irq_i,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        tx_ok_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    ST_INIT, ST_READY, ST_LOAD, ST_CMD, ST_POLL, ST_FINISH
  } step_t;

  typedef enum logic [1:0] {
    BUS_IDLE, BUS_REQ, BUS_WAIT_GNT, BUS_WAIT_RVALID
  } bus_t;

  // 21 bits holds the largest allowed limit of 2^20
  localparam logic [20:0] LIMIT = 21'(POLL_LIMIT);

  step_t       step, step_n;
  bus_t        bus, bus_n;
  logic [3:0]  idx, idx_n;
  logic [1:0]  gap, gap_n;
  logic [20:0] cnt, cnt_n;
  logic [10:0] id_q, id_n;
  logic        rtr_q, rtr_n;
  logic [3:0]  dlc_q, dlc_n;
  logic [63:0] data_q, data_n;
  logic        req_q, req_n;
  logic        we_q, we_n;
  logic [4:0]  addr_q, addr_n;
  logic [7:0]  wdata_q, wdata_n;
  logic        tx_ok_q, tx_ok_n;
  logic        timeout_q, timeout_n;

  logic        xfer_done;
  logic        hit;
  logic        sel_we;
  logic [4:0]  sel_addr;
  logic [7:0]  sel_wdata;
  logic [3:0]  n_bytes;
  logic [3:0]  last_idx;

  // Only status bit 3 matters; the remaining read bits are deliberately dropped
`ifdef CAN_HOST_SEQ_IRQ_EN
  logic unused_bits;
  assign unused_bits = ^{rdata_i[31:4], rdata_i[2:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{rdata_i[31:4], rdata_i[2:0], irq_i};
`endif

  // Payload byte count is clamped to 8, but ID2 still carries the raw dlc
  assign n_bytes  = (dlc_q > 4'd8) ? 4'd8 : dlc_q;
  assign last_idx = n_bytes + 4'd1;
  assign hit      = (cnt >= LIMIT);

  assign req_o     = req_q;
  assign we_o      = we_q;
  assign addr_o    = {27'd0, addr_q};
  assign wdata_o   = {24'd0, wdata_q};
  assign be_o      = 4'b0001;
  assign ready_o   = (step == ST_READY);
  assign busy_o    = ~ready_o;
  assign done_o    = (step == ST_FINISH);
  assign tx_ok_o   = tx_ok_q;
  assign timeout_o = timeout_q;

  // State and datapath register. Reset drops any outstanding transaction and
  // restarts INIT straight into a bus request on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      step      <= ST_INIT;
      bus       <= BUS_REQ;
      idx       <= 4'd0;
      gap       <= 2'd0;
      cnt       <= 21'd0;
      id_q      <= 11'd0;
      rtr_q     <= 1'b0;
      dlc_q     <= 4'd0;
      data_q    <= 64'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 5'd0;
      wdata_q   <= 8'd0;
      tx_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      step      <= step_n;
      bus       <= bus_n;
      idx       <= idx_n;
      gap       <= gap_n;
      cnt       <= cnt_n;
      id_q      <= id_n;
      rtr_q     <= rtr_n;
      dlc_q     <= dlc_n;
      data_q    <= data_n;
      req_q     <= req_n;
      we_q      <= we_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      tx_ok_q   <= tx_ok_n;
      timeout_q <= timeout_n;
    end
  end

  // Next-state logic. The bus phase runs one transaction for whichever step
  // is current; when the response arrives the step advances and, if it needs
  // another access, goes straight back to BUS_REQ so each access costs three
  // cycles with a zero-wait slave.
  always_comb begin
    step_n    = step;
    bus_n     = bus;
    idx_n     = idx;
    gap_n     = gap;
    cnt_n     = cnt;
    id_n      = id_q;
    rtr_n     = rtr_q;
    dlc_n     = dlc_q;
    data_n    = data_q;
    req_n     = req_q;
    we_n      = we_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    tx_ok_n   = tx_ok_q;
    timeout_n = timeout_q;
    xfer_done = 1'b0;
    sel_we    = 1'b1;
    sel_addr  = 5'd0;
    sel_wdata = 8'd0;

    // Register access wanted by the current step and step index
    case (step)
      ST_INIT: begin
        case (idx)
          4'd0:    begin sel_addr = 5'd0; sel_wdata = 8'h01;    end
          4'd1:    begin sel_addr = 5'd6; sel_wdata = BTR0_VAL; end
          4'd2:    begin sel_addr = 5'd7; sel_wdata = BTR1_VAL; end
          default: begin sel_addr = 5'd0; sel_wdata = 8'h00;    end
        endcase
      end
      ST_LOAD: begin
        if (idx == 4'd0) begin
          sel_addr  = 5'd10;
          sel_wdata = id_q[10:3];
        end else if (idx == 4'd1) begin
          sel_addr  = 5'd11;
          sel_wdata = {id_q[2:0], rtr_q, dlc_q};
        end else begin
          sel_addr  = {1'b0, idx} + 5'd10;
          sel_wdata = data_q[{idx - 4'd2, 3'b000} +: 8];
        end
      end
      ST_CMD: begin
        sel_addr  = 5'd1;
        sel_wdata = 8'h01;
      end
      ST_POLL: begin
        sel_we    = 1'b0;
        sel_addr  = 5'd2;
      end
      default: ;
    endcase

    // Timeout counter runs in every POLL cycle, bus waits included
    if (step == ST_POLL && !hit)
      cnt_n = cnt + 21'd1;

    // Bus handshake; rvalid is only honoured once this request is granted
    case (bus)
      BUS_REQ: begin
        req_n   = 1'b1;
        we_n    = sel_we;
        addr_n  = sel_addr;
        wdata_n = sel_wdata;
        bus_n   = BUS_WAIT_GNT;
      end
      BUS_WAIT_GNT: begin
        if (gnt_i) begin
          req_n = 1'b0;
          if (rvalid_i)
            xfer_done = 1'b1;
          else
            bus_n = BUS_WAIT_RVALID;
        end
      end
      BUS_WAIT_RVALID: begin
        if (rvalid_i)
          xfer_done = 1'b1;
      end
      default: ;
    endcase

    if (xfer_done) begin
      bus_n = BUS_IDLE;
      case (step)
        ST_INIT: begin
          if (idx == 4'd3) begin
            step_n = ST_READY;
            idx_n  = 4'd0;
          end else begin
            idx_n = idx + 4'd1;
            bus_n = BUS_REQ;
          end
        end
        ST_LOAD: begin
          if (idx == last_idx) begin
            step_n = ST_CMD;
            idx_n  = 4'd0;
          end else begin
            idx_n = idx + 4'd1;
          end
          bus_n = BUS_REQ;
        end
        ST_CMD: begin
          step_n = ST_POLL;
          cnt_n  = 21'd0;
          gap_n  = 2'd0;
`ifdef CAN_HOST_SEQ_IRQ_EN
          bus_n  = BUS_IDLE;
`else
          bus_n  = BUS_REQ;
`endif
        end
        ST_POLL: begin
          // A completed frame wins even if the limit was hit on this read
          if (rdata_i[3]) begin
            step_n    = ST_FINISH;
            tx_ok_n   = 1'b1;
            timeout_n = 1'b0;
          end else if (hit) begin
            step_n    = ST_FINISH;
            tx_ok_n   = 1'b0;
            timeout_n = 1'b1;
          end else begin
            gap_n = 2'd0;
          end
        end
        default: ;
      endcase
    end else if (bus == BUS_IDLE) begin
      case (step)
        ST_READY: begin
          if (start_i) begin
            id_n   = id_i;
            rtr_n  = rtr_i;
            dlc_n  = dlc_i;
            data_n = data_i;
            step_n = ST_LOAD;
            idx_n  = 4'd0;
            bus_n  = BUS_REQ;
          end
        end
        ST_POLL: begin
`ifdef CAN_HOST_SEQ_IRQ_EN
          if (hit) begin
            step_n    = ST_FINISH;
            tx_ok_n   = 1'b0;
            timeout_n = 1'b1;
          end else if (irq_i) begin
            bus_n = BUS_REQ;
          end
`else
          if (gap == 2'd3)
            bus_n = BUS_REQ;
          else
            gap_n = gap + 2'd1;
`endif
        end
        ST_FINISH: begin
          step_n = ST_READY;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_can_host_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_can_host_seq
//
// Directed bench for can_host_seq. A behavioural register slave grants and
// answers requests with fixed or random delays, logs every granted access
// as {we, addr[7:0], wdata[7:0]}, and flags protocol problems (fields moving
// before grant, a request while a response is owed, bad be/upper bits).
// Status reads return 0xF7 (bit 3 clear) until the configured poll number,
// then 0x08.
// ---------------------------------------------------------------------------
module tb_can_host_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [10:0] id_i;
  logic        rtr_i;
  logic [3:0]  dlc_i;
  logic [63:0] data_i;
  logic        irq_i;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [3:0]  be_o;
  logic [31:0] wdata_o;
  logic        gnt_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic        tx_ok_o;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  // slave model state
  logic [16:0] log_q[$];
  int          proto_err  = 0;
  int          poll_n     = 0;
  int          poll_ok_at = 1;
  bit          rnd_en     = 0;
  int          gnt_fix    = 0;
  int          rv_fix     = 1;
  bit          pend       = 0;
  int          rv_wait    = 0;
  logic [31:0] pend_data  = '0;
  bit          holding    = 0;
  int          g_wait     = 0;
  logic        h_we;
  logic [31:0] h_addr;
  logic [31:0] h_wdata;

  can_host_seq #(
    .BTR0_VAL  (8'h43),
    .BTR1_VAL  (8'h2F),
    .POLL_LIMIT(64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .id_i     (id_i),
    .rtr_i    (rtr_i),
    .dlc_i    (dlc_i),
    .data_i   (data_i),
    .irq_i    (irq_i),
    .req_o    (req_o),
    .we_o     (we_o),
    .addr_o   (addr_o),
    .be_o     (be_o),
    .wdata_o  (wdata_o),
    .gnt_i    (gnt_i),
    .rvalid_i (rvalid_i),
    .rdata_i  (rdata_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .tx_ok_o  (tx_ok_o),
    .timeout_o(timeout_o)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register slave: acts on the falling edge so the DUT sees stable
  // handshake inputs at the next rising edge.
  initial begin
    logic [31:0] resp;
    int          rv;
    gnt_i    = 1'b0;
    rvalid_i = 1'b0;
    rdata_i  = '0;
    forever begin
      @(negedge clk);
      gnt_i    = 1'b0;
      rvalid_i = 1'b0;
      if (pend) begin
        if (req_o) proto_err++;
        if (rv_wait == 0) begin
          rvalid_i = 1'b1;
          rdata_i  = pend_data;
          pend     = 0;
        end else begin
          rv_wait--;
        end
      end else if (req_o) begin
        if (!holding) begin
          holding = 1;
          h_we    = we_o;
          h_addr  = addr_o;
          h_wdata = wdata_o;
          g_wait  = rnd_en ? int'($urandom_range(7, 0)) : gnt_fix;
        end else if (we_o !== h_we || addr_o !== h_addr || wdata_o !== h_wdata) begin
          proto_err++;
        end
        if (be_o !== 4'b0001 || wdata_o[31:8] !== 24'd0 || addr_o[31:8] !== 24'd0)
          proto_err++;
        if (g_wait == 0) begin
          gnt_i   = 1'b1;
          holding = 0;
          log_q.push_back({we_o, addr_o[7:0], wdata_o[7:0]});
          if (!we_o && addr_o == 32'd2) begin
            poll_n++;
            resp = (poll_ok_at != 0 && poll_n >= poll_ok_at) ? 32'h08 : 32'hF7;
          end else begin
            resp = 32'h0;
          end
          rv = rnd_en ? int'($urandom_range(7, 0)) : rv_fix;
          if (rv == 0) begin
            rvalid_i = 1'b1;
            rdata_i  = resp;
          end else begin
            pend      = 1;
            rv_wait   = rv - 1;
            pend_data = resp;
          end
        end else begin
          g_wait--;
        end
      end else begin
        holding = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkLog(input string tag, input int i, input logic we, input logic [7:0] addr,
                          input logic [7:0] data);
    logic [31:0] obs;
    obs = (i < log_q.size()) ? {15'd0, log_q[i]} : 32'hFFFF_FFFF;
    checkOutput(tag, obs, {15'd0, we, addr, data});
  endtask

  task automatic applyStimulus(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                               input logic [63:0] data);
    @(negedge clk);
    id_i    = id;
    rtr_i   = rtr;
    dlc_i   = dlc;
    data_i  = data;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic waitReady(input string tag, input int bound);
    logic got;
    got = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput(tag, {31'd0, got}, 32'd1);
  endtask

  task automatic waitDone(input string tag, input int bound);
    logic got;
    got = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput(tag, {31'd0, got}, 32'd1);
  endtask

  task automatic countReq(input int n, output int cycles);
    cycles = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (req_o) cycles++;
    end
  endtask

  task automatic checkInit(input string tag);
    checkLog({tag, "_w0"}, 0, 1'b1, 8'd0, 8'h01);
    checkLog({tag, "_w1"}, 1, 1'b1, 8'd6, 8'h43);
    checkLog({tag, "_w2"}, 2, 1'b1, 8'd7, 8'h2F);
    checkLog({tag, "_w3"}, 3, 1'b1, 8'd0, 8'h00);
    checkOutput({tag, "_count"}, 32'(log_q.size()), 32'd4);
  endtask

  // Directed sequence
  initial begin
    int reqs;
    logic [7:0] b;
    rst     = 1'b1;
    start_i = 1'b0;
    id_i    = '0;
    rtr_i   = 1'b0;
    dlc_i   = '0;
    data_i  = '0;
    irq_i   = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_req",     {31'd0, req_o},     32'd0);
    checkOutput("rst_we",      {31'd0, we_o},      32'd0);
    checkOutput("rst_addr",    addr_o,             32'd0);
    checkOutput("rst_wdata",   wdata_o,            32'd0);
    checkOutput("rst_be",      {28'd0, be_o},      32'd1);
    checkOutput("rst_ready",   {31'd0, ready_o},   32'd0);
    checkOutput("rst_busy",    {31'd0, busy_o},    32'd1);
    checkOutput("rst_done",    {31'd0, done_o},    32'd0);
    checkOutput("rst_tx_ok",   {31'd0, tx_ok_o},   32'd0);
    checkOutput("rst_timeout", {31'd0, timeout_o}, 32'd0);

    // init sequence with a zero-wait slave
    $display("[TB] init sequence");
    rst = 1'b0;
    waitReady("init_ready", 200);
    checkOutput("init_busy", {31'd0, busy_o}, 32'd0);
    checkInit("init");

    // basic frame, success on the third status read
    $display("[TB] dlc=3 frame");
    log_q.delete();
    poll_n     = 0;
    poll_ok_at = 3;
    applyStimulus(11'h123, 1'b0, 4'd3, 64'h0000_0000_00AB_0011);
    checkOutput("tx1_busy", {31'd0, busy_o}, 32'd1);
    waitDone("tx1_done", 500);
    checkOutput("tx1_ok",      {31'd0, tx_ok_o},   32'd1);
    checkOutput("tx1_timeout", {31'd0, timeout_o}, 32'd0);
    checkLog("tx1_id1",  0, 1'b1, 8'd10, 8'h24);
    checkLog("tx1_id2",  1, 1'b1, 8'd11, 8'h63);
    checkLog("tx1_d0",   2, 1'b1, 8'd12, 8'h11);
    checkLog("tx1_d1",   3, 1'b1, 8'd13, 8'h00);
    checkLog("tx1_d2",   4, 1'b1, 8'd14, 8'hAB);
    checkLog("tx1_cmd",  5, 1'b1, 8'd1,  8'h01);
    checkLog("tx1_rd0",  6, 1'b0, 8'd2,  8'h00);
    checkLog("tx1_rd2",  8, 1'b0, 8'd2,  8'h00);
    checkOutput("tx1_count", 32'(log_q.size()), 32'd9);
    @(negedge clk);
    checkOutput("tx1_done_pulse", {31'd0, done_o}, 32'd0);
    checkOutput("tx1_ready_after", {31'd0, ready_o}, 32'd1);

    // dlc=15: raw dlc in ID2, payload clamped to 8 bytes
    $display("[TB] dlc=15 frame");
    log_q.delete();
    poll_n     = 0;
    poll_ok_at = 1;
    applyStimulus(11'h555, 1'b1, 4'd15, 64'h8877_6655_4433_2211);
    waitDone("tx2_done", 500);
    checkOutput("tx2_ok", {31'd0, tx_ok_o}, 32'd1);
    checkLog("tx2_id1", 0, 1'b1, 8'd10, 8'hAA);
    checkLog("tx2_id2", 1, 1'b1, 8'd11, 8'hBF);
    for (int i = 0; i < 8; i++) begin
      b = 8'((i + 1) * 17);
      checkLog($sformatf("tx2_d%0d", i), 2 + i, 1'b1, 8'(12 + i), b);
    end
    checkLog("tx2_cmd", 10, 1'b1, 8'd1, 8'h01);
    checkOutput("tx2_count", 32'(log_q.size()), 32'd12);

    // timeout: status never completes, dlc=0 skips data writes
    $display("[TB] timeout frame");
    log_q.delete();
    poll_n     = 0;
    poll_ok_at = 0;
    applyStimulus(11'h001, 1'b0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    waitDone("tx3_done", 1000);
    checkOutput("tx3_ok",      {31'd0, tx_ok_o},   32'd0);
    checkOutput("tx3_timeout", {31'd0, timeout_o}, 32'd1);
    checkLog("tx3_id2", 1, 1'b1, 8'd11, 8'h20);
    checkLog("tx3_cmd", 2, 1'b1, 8'd1,  8'h01);
    checkOutput("tx3_polled", {31'd0, (poll_n >= 2) ? 1'b1 : 1'b0}, 32'd1);
    countReq(40, reqs);
    checkOutput("tx3_no_req_after", 32'(reqs), 32'd0);

    // random handshake delays plus a start while busy
    $display("[TB] random delays");
    log_q.delete();
    poll_n     = 0;
    poll_ok_at = 1;
    rnd_en     = 1;
    applyStimulus(11'h2C4, 1'b0, 4'd2, 64'h0000_0000_0000_BEEF);
    repeat (5) @(negedge clk);
    id_i    = 11'h7AA;
    dlc_i   = 4'd1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    waitDone("tx4_done", 3000);
    checkOutput("tx4_ok", {31'd0, tx_ok_o}, 32'd1);
    checkLog("tx4_id1", 0, 1'b1, 8'd10, 8'h58);
    checkLog("tx4_id2", 1, 1'b1, 8'd11, 8'h82);
    checkLog("tx4_d0",  2, 1'b1, 8'd12, 8'hEF);
    checkLog("tx4_d1",  3, 1'b1, 8'd13, 8'hBE);
    checkLog("tx4_cmd", 4, 1'b1, 8'd1,  8'h01);
    countReq(60, reqs);
    checkOutput("tx4_no_second", 32'(reqs), 32'd0);
    checkOutput("tx4_count", 32'(log_q.size()), 32'd6);
    checkOutput("protocol_errors", 32'(proto_err), 32'd0);

    // reset while a LOAD write awaits rvalid; the stale rvalid must be ignored
    $display("[TB] reset mid-load");
    rnd_en  = 0;
    gnt_fix = 0;
    rv_fix  = 12;
    log_q.delete();
    applyStimulus(11'h3FF, 1'b0, 4'd8, 64'h0102_0304_0506_0708);
    begin
      logic got;
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
        if (log_q.size() == 2 && pend) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      checkOutput("rst6_reached_load", {31'd0, got}, 32'd1);
    end
    rst = 1'b1;
    log_q.delete();
    repeat (2) @(negedge clk);
    checkOutput("rst6_tx_ok",  {31'd0, tx_ok_o}, 32'd0);
    checkOutput("rst6_ready",  {31'd0, ready_o}, 32'd0);
    rst    = 1'b0;
    rv_fix = 1;
    waitReady("rst6_init_ready", 300);
    checkInit("rst6");
    countReq(30, reqs);
    checkOutput("rst6_frame_dropped", 32'(reqs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
